shift_sequencer: RTL and testbench

Command-driven sequencer for the lab's 8-bit load/rotate/arithmetic-shift register. It accepts a one-cycle command (data, mode, shift amount), performs the parallel load, and drives the register's load, direction and arithmetic controls for exactly the requested number of cycles. It then holds the result and pulses `done`. It owns its register instance, so upstream logic issues operations instead of toggling control lines by hand.

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_reg8.sv | 37 +++
 rtl/shift_sequencer.sv | 104 ++++++++++
 tb/tb_shift_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer and its register datapath.
package shift_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_AMT_W = 3;

    typedef enum logic [1:0] {
        MODE_ROR  = 2'b00,
        MODE_ROL  = 2'b01,
        MODE_ASR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/status bundle between an issuer (master) and the sequencer (slave).
interface shift_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (
        output start, mode, amount, data_in,
        input  busy, done, q
    );

    modport slave (
        input  start, mode, amount, data_in,
        output busy, done, q
    );
endinterface

// File: rtl/shift_reg8.sv
// Load / rotate / arithmetic-shift-right register datapath.
module shift_reg8
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             par_loadn_i,
    input  logic             rotate_right_i,
    input  logic             as_right_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] left_nb;
    logic [WIDTH-1:0] right_nb;

    // Neighbour selection per bit; the top bit's left input is q[0] (rotate) or q[MSB] (sign fill).
    always_comb begin
        left_nb  = {(as_right_i ? q_q[WIDTH-1] : q_q[0]), q_q[WIDTH-1:1]};
        right_nb = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_d      = par_loadn_i ? (rotate_right_i ? left_nb : right_nb) : d_i;
    end

    // Register update with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer: load, then shift the owned register N times, then pulse done.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AMT_W = DEF_AMT_W
) (
    input  logic             clock,
    input  logic             reset,
    shift_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             par_loadn;
    logic             rotate_right;
    logic             as_right;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;
    logic             reg_rst;

    // State, counter and command registers; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_ROR;
            amt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
        end
    end

    // Next-state and register control decode; idle/done reload q so it holds.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        amt_d        = amt_q;
        data_d       = data_q;
        par_loadn    = 1'b0;
        rotate_right = 1'b0;
        as_right     = 1'b0;
        reg_d        = reg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d  = mode_e'(bus.mode);
                    amt_d   = bus.amount;
                    data_d  = bus.data_in;
                    cnt_d   = bus.amount;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                reg_d = data_q;
                if (amt_q != '0 && mode_q != MODE_LOAD) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                par_loadn    = 1'b1;
                rotate_right = (mode_q != MODE_ROL);
                as_right     = (mode_q == MODE_ASR);
                cnt_d        = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign reg_rst = ~reset;

    shift_reg8 #(.WIDTH(WIDTH)) u_reg (
        .clk_i          (clock),
        .rst_i          (reg_rst),
        .par_loadn_i    (par_loadn),
        .rotate_right_i (rotate_right),
        .as_right_i     (as_right),
        .d_i            (reg_d),
        .q_o            (reg_q)
    );

    assign bus.busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.q    = reg_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: behavioural timeline model plus directed literals.
module tb_shift_sequencer;

    logic clock;
    logic reset;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic       busy;
        logic       done;
        logic [7:0] q;
    } exp_t;

    exp_t pend[$];
    exp_t cur = '{1'b0, 1'b0, 8'h00};

    function automatic logic [7:0] shift1(input logic [1:0] m, input logic [7:0] v);
        case (m)
            2'd0:    return (v >> 1) | ((v & 8'h01) << 7);
            2'd1:    return (v << 1) | (v >> 7);
            2'd2:    return (v >> 1) | (v & 8'h80);
            default: return v;
        endcase
    endfunction

    // One entry per post-edge cycle: load cycle, N shift cycles, then the done cycle.
    always @(posedge clock) begin
        if (!reset) begin
            pend.delete();
            cur = '{1'b0, 1'b0, 8'h00};
        end else if (!cur.busy && !cur.done && bus.start) begin
            int n;
            logic [7:0] v;
            n = (bus.mode == 2'd3) ? 0 : int'(bus.amount);
            v = bus.data_in;
            pend.delete();
            pend.push_back('{1'b1, 1'b0, cur.q});
            for (int k = 0; k < n; k++) begin
                pend.push_back('{1'b1, 1'b0, v});
                v = shift1(bus.mode, v);
            end
            pend.push_back('{1'b0, 1'b1, v});
            cur = pend.pop_front();
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else begin
            cur.busy = 1'b0;
            cur.done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_busy", {7'd0, bus.busy}, {7'd0, cur.busy});
            check("model_done", {7'd0, bus.done}, {7'd0, cur.done});
            check("model_q", bus.q, cur.q);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int c0, output int lat, output int busyc);
        lat   = c0;
        busyc = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (bus.busy === 1'b1) busyc++;
            @(negedge clock);
            lat++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_cmd(input string name, input logic [1:0] m, input logic [2:0] a,
                           input logic [7:0] d, input logic [7:0] exp_q, input int exp_lat);
        int lat, busyc;
        bus.start = 1'b1; bus.mode = m; bus.amount = a; bus.data_in = d;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(1, lat, busyc);
        check({name, "_latency"}, 8'(lat), 8'(exp_lat));
        check({name, "_busycycles"}, 8'(busyc), 8'(exp_lat - 1));
        check({name, "_q"}, bus.q, exp_q);
        @(negedge clock);
    endtask

    initial begin
        int lat, busyc;
        logic saw_done;

        reset = 1'b0;
        bus.start = 1'b0; bus.mode = 2'd0; bus.amount = 3'd0; bus.data_in = 8'h00;
        repeat (2) @(negedge clock);
        check("reset_q", bus.q, 8'h00);
        check("reset_busy", {7'd0, bus.busy}, 8'h00);
        check("reset_done", {7'd0, bus.done}, 8'h00);
        chk_en = 1'b1;
        reset  = 1'b1;
        @(negedge clock);

        run_cmd("ror81x1", 2'd0, 3'd1, 8'h81, 8'hC0, 3);
        run_cmd("rol81x3", 2'd1, 3'd3, 8'h81, 8'h0C, 5);
        run_cmd("asr80x7", 2'd2, 3'd7, 8'h80, 8'hFF, 9);
        run_cmd("asr40x2", 2'd2, 3'd2, 8'h40, 8'h10, 4);

        run_cmd("amt0", 2'd0, 3'd0, 8'h5A, 8'h5A, 2);
        repeat (10) @(negedge clock);
        check("amt0_hold", bus.q, 8'h5A);
        run_cmd("loadonly", 2'd3, 3'd5, 8'h5A, 8'h5A, 2);
        repeat (10) @(negedge clock);
        check("loadonly_hold", bus.q, 8'h5A);

        // Second start while busy must be dropped.
        bus.start = 1'b1; bus.mode = 2'd0; bus.amount = 3'd7; bus.data_in = 8'hF0;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        bus.start = 1'b1; bus.mode = 2'd1; bus.amount = 3'd2; bus.data_in = 8'h00;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(4, lat, busyc);
        check("ignore_latency", 8'(lat), 8'd9);
        check("ignore_q", bus.q, 8'hE1);
        @(negedge clock);
        run_cmd("after_ignore", 2'd1, 3'd1, 8'h81, 8'h03, 3);

        // Reset in the middle of an ASR.
        bus.start = 1'b1; bus.mode = 2'd2; bus.amount = 3'd6; bus.data_in = 8'hAA;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_q", bus.q, 8'h00);
        check("midreset_busy", {7'd0, bus.busy}, 8'h00);
        check("midreset_done", {7'd0, bus.done}, 8'h00);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("midreset_nodone", {7'd0, saw_done}, 8'h00);
        run_cmd("after_reset", 2'd2, 3'd2, 8'h40, 8'h10, 4);

        // Randomized traffic: random strobes (often while busy) and rare resets.
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) != 0);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.mode     = 2'($urandom);
            bus.amount   = 3'($urandom);
            bus.data_in  = 8'($urandom);
            @(negedge clock);
        end
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (12) @(negedge clock);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
